// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS = 4;

    typedef enum logic [1:0] {
        IC_IDLE  = 2'd0,
        IC_MISS  = 2'd1,
        IC_DRAIN = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tag and data contents are meaningless until valid.
module icache_array #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [31:0]         data_mem [LINES];

    // Valid bits: cleared by reset, set on every line fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data storage written on fill.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word misses.
// A flush cancels delivery of a pending miss but the memory fetch always
// completes and still fills the line (DRAIN state).
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        req_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        clear,
    output logic        mem_fetch_enable,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    ic_state_e    state_q;
    logic [29:0]  line_addr_q;   // word address of the outstanding miss
    logic         inst_valid_q;
    logic [31:0]  inst_q;
    logic         mem_fetch_enable_q;

    logic [INDEX_BITS-1:0] rd_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  accept;
    logic                  fill_en;
    logic                  unused_pc_bits;

    assign unused_pc_bits = &{1'b0, fetch_pc[1:0]};

    assign rd_index  = fetch_pc[INDEX_BITS+1:2];
    assign pc_tag    = fetch_pc[31:INDEX_BITS+2];
    assign hit       = rd_valid && (rd_tag == pc_tag);
    assign req_ready = (state_q == IC_IDLE) && rdy && !clear;
    assign accept    = fetch_req && req_ready;

    // A returning word fills the line whether or not delivery was cancelled.
    assign fill_en = rst && rdy && mem_valid &&
                     ((state_q == IC_MISS) || (state_q == IC_DRAIN));

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (rd_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_index_i (line_addr_q[INDEX_BITS-1:0]),
        .wr_tag_i   (line_addr_q[29:INDEX_BITS]),
        .wr_data_i  (mem_data)
    );

    // Control FSM with registered outputs; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q            <= IC_IDLE;
            line_addr_q        <= '0;
            inst_valid_q       <= 1'b0;
            inst_q             <= '0;
            mem_fetch_enable_q <= 1'b0;
        end else if (rdy) begin
            inst_valid_q <= 1'b0;
            case (state_q)
                IC_IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= rd_data;
                        end else begin
                            line_addr_q        <= fetch_pc[31:2];
                            mem_fetch_enable_q <= 1'b1;
                            state_q            <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (mem_valid) begin
                        mem_fetch_enable_q <= 1'b0;
                        state_q            <= IC_IDLE;
                        if (!clear) begin
                            inst_valid_q <= 1'b1;
                            inst_q       <= mem_data;
                        end
                    end else if (clear) begin
                        // Controller may already own the address; wait it out.
                        state_q <= IC_DRAIN;
                    end
                end
                IC_DRAIN: begin
                    if (mem_valid) begin
                        mem_fetch_enable_q <= 1'b0;
                        state_q            <= IC_IDLE;
                    end
                end
                default: begin
                    state_q <= IC_IDLE;
                end
            endcase
        end
    end

    assign inst_valid       = inst_valid_q;
    assign inst             = inst_q;
    assign mem_fetch_enable = mem_fetch_enable_q;
    assign mem_addr         = {line_addr_q, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed requests push expected instructions,
// a monitor pops and compares on each inst_valid pulse.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        req_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic        clear;
    logic        mem_fetch_enable;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    icache #(.INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .fetch_req        (fetch_req),
        .fetch_pc         (fetch_pc),
        .req_ready        (req_ready),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .clear            (clear),
        .mem_fetch_enable (mem_fetch_enable),
        .mem_addr         (mem_addr),
        .mem_valid        (mem_valid),
        .mem_data         (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every delivered instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (inst_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got inst=%h want no delivery", inst);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst !== e) begin
                    bad++;
                    $display("FAIL sb_inst: got=%h want=%h", inst, e);
                end else begin
                    $display("ok   sb_inst: %h", inst);
                end
            end
        end
    end

    // Issue one request; hit expectation decides scoreboard push vs. miss checks.
    task automatic request(input logic [31:0] pc, input logic is_hit, input logic [31:0] data);
        chk("req_ready_before", {31'b0, req_ready}, 32'd1);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        if (is_hit) exp_q.push_back(data);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(negedge clk);
        if (is_hit) begin
            chk("hit_valid", {31'b0, inst_valid}, 32'd1);
            chk("hit_no_fetch", {31'b0, mem_fetch_enable}, 32'd0);
        end else begin
            chk("miss_enable", {31'b0, mem_fetch_enable}, 32'd1);
            chk("miss_addr", mem_addr, {pc[31:2], 2'b00});
            chk("miss_req_ready", {31'b0, req_ready}, 32'd0);
        end
    endtask

    // Memory returns a word after some wait cycles, optionally with a coincident clear.
    task automatic respond(input int wait_cyc, input logic [31:0] data, input logic clr, input logic deliver);
        repeat (wait_cyc) @(negedge clk);
        mem_valid = 1'b1;
        mem_data  = data;
        clear     = clr;
        if (deliver) exp_q.push_back(data);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        clear     = 1'b0;
        @(negedge clk);
        chk("fill_enable_drop", {31'b0, mem_fetch_enable}, 32'd0);
        chk("fill_valid", {31'b0, inst_valid}, {31'b0, deliver});
        chk("fill_idle", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        rdy       = 1'b1;
        fetch_req = 1'b0;
        fetch_pc  = '0;
        clear     = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_enable", {31'b0, mem_fetch_enable}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // Cold miss, then hit, then back-to-back hits
        request(32'h0000_0040, 1'b0, 32'h0);
        respond(2, 32'h00A0_0093, 1'b0, 1'b1);
        request(32'h0000_0040, 1'b1, 32'h00A0_0093);
        request(32'h0000_0044, 1'b0, 32'h0);
        respond(1, 32'h0010_0113, 1'b0, 1'b1);
        request(32'h0000_0040, 1'b1, 32'h00A0_0093);
        request(32'h0000_0044, 1'b1, 32'h0010_0113);

        // Conflict eviction on index 0
        request(32'h0000_0000, 1'b0, 32'h0);
        respond(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        request(32'h0000_0040, 1'b0, 32'h0);
        respond(0, 32'h00A0_0093, 1'b0, 1'b1);

        // Clear in IDLE blocks acceptance
        fetch_req = 1'b1;
        fetch_pc  = 32'h0000_0040;
        clear     = 1'b1;
        #1;
        chk("clr_idle_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        clear     = 1'b0;
        @(negedge clk);
        chk("clr_idle_valid", {31'b0, inst_valid}, 32'd0);
        chk("clr_idle_enable", {31'b0, mem_fetch_enable}, 32'd0);

        // Clear mid-miss: drain, fill, no delivery, then hit
        request(32'h0000_0080, 1'b0, 32'h0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("drain_ready", {31'b0, req_ready}, 32'd0);
        chk("drain_enable", {31'b0, mem_fetch_enable}, 32'd1);
        clear = 1'b1;   // no effect while draining
        @(negedge clk);
        clear = 1'b0;
        respond(0, 32'h1234_5678, 1'b0, 1'b0);
        request(32'h0000_0080, 1'b1, 32'h1234_5678);

        // Clear coincident with mem_valid
        request(32'h0000_00C0, 1'b0, 32'h0);
        respond(1, 32'h0BAD_F00D, 1'b1, 1'b0);
        request(32'h0000_00C0, 1'b1, 32'h0BAD_F00D);

        // rdy low freezes a miss
        request(32'h0000_0100, 1'b0, 32'h0);
        rdy = 1'b0;
        repeat (5) @(negedge clk);
        chk("frz_enable", {31'b0, mem_fetch_enable}, 32'd1);
        chk("frz_addr", mem_addr, 32'h0000_0100);
        chk("frz_ready", {31'b0, req_ready}, 32'd0);
        rdy = 1'b1;
        respond(1, 32'h1111_1111, 1'b0, 1'b1);
        request(32'h0000_0100, 1'b1, 32'h1111_1111);

        // Reset mid-miss drops the miss and invalidates everything
        request(32'h0000_0200, 1'b0, 32'h0);
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("rst_miss_enable", {31'b0, mem_fetch_enable}, 32'd0);
        chk("rst_miss_addr", mem_addr, 32'd0);
        chk("rst_miss_valid", {31'b0, inst_valid}, 32'd0);
        // Spurious mem_valid in IDLE is ignored
        mem_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("spurious_valid", {31'b0, inst_valid}, 32'd0);
        request(32'h0000_0200, 1'b0, 32'h0);
        respond(1, 32'h2222_2222, 1'b0, 1'b1);
        request(32'h0000_0040, 1'b0, 32'h0);
        respond(1, 32'h00A0_0093, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch unit (upstream) and the memory controller's fetch port (downstream).
- Hits return a 32-bit instruction one cycle after acceptance.
- Misses issue a single-word fetch to the memory controller, fill the line and forward the word.
- A pipeline clear cancels delivery but never aborts an in-flight memory fetch.

Parameters:
INDEX_BITS, 4, line-index width; 2**INDEX_BITS lines of one 32-bit word each
TAG_BITS, 30-INDEX_BITS, derived; tag = pc[31:INDEX_BITS+2]

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset (rst==0 resets on posedge clk)
rdy  in  1  global ready; 0 freezes all state and outputs
fetch_req  in  1  fetch unit requests instruction at fetch_pc
fetch_pc  in  32  request address; bits [1:0] ignored
req_ready  out  1  combinational: state==IDLE && rdy && !clear; accept = fetch_req && req_ready
inst_valid  out  1  one-cycle pulse: inst holds requested word
inst  out  32  returned instruction
clear  in  1  mispredict flush from ROB
mem_fetch_enable  out  1  request to memory controller fetch port
mem_addr  out  32  word-aligned fetch address {pc[31:2],2'b00}
mem_valid  in  1  memory controller fetch-done pulse (one cycle)
mem_data  in  32  fetched word, valid with mem_valid

Behaviour:
- Reset (rst==0 at posedge): all line valid bits 0; state IDLE; inst_valid 0; inst 0; mem_fetch_enable 0; mem_addr 0. Reset mid-miss drops the miss; no fill occurs.
- rdy==0: no state, array or output changes; req_ready 0.
- Index = pc[INDEX_BITS+1:2]. Hit = valid[index] && tag[index]==pc[31:INDEX_BITS+2].
- States: IDLE, MISS, DRAIN.
- IDLE, accept with hit: next cycle inst_valid=1, inst=data[index]; state stays IDLE. Back-to-back hits give one instruction per cycle.
- IDLE, accept with miss: latch pc; next cycle mem_fetch_enable=1, mem_addr={pc[31:2],2'b00}, inst_valid=0; go to MISS.
- IDLE, no accept: inst_valid=0.
- MISS, mem_valid && !clear:
  - write data/tag/valid at the latched index;
  - next cycle inst_valid=1, inst=mem_data, mem_fetch_enable=0;
  - go to IDLE.
- MISS, clear && !mem_valid: go to DRAIN; mem_fetch_enable stays 1. The controller may already have latched the address.
- MISS, clear && mem_valid in the same cycle: fill the line; inst_valid stays 0; go to IDLE.
- DRAIN: on mem_valid, fill the line (data is correct for the latched address), inst_valid 0, mem_fetch_enable 0, go to IDLE. clear in DRAIN has no effect.
- mem_fetch_enable drops the cycle after mem_valid, while the controller is in its post-transfer stall. A new miss can therefore assert enable no earlier than the controller's return to IDLE, so no duplicate fetch is possible.
- clear in IDLE blocks acceptance that cycle and forces inst_valid=0 next cycle.
  - A hit response already high in the clear cycle is not retracted; the fetch unit gives clear priority.
- fetch_req/fetch_pc in MISS/DRAIN are ignored (req_ready=0). The fetch unit holds them stable until accepted.
- mem_valid in IDLE is spurious and ignored: no fill, no output.
- Cache is never invalidated except by reset; there is no self-modifying-code support.

Decomposition:
- Shared const_def package: ICACHE state encodings (IC_IDLE/IC_MISS/IC_DRAIN), default ICACHE_INDEX_BITS.
- One sub-module, icache_array: valid/tag/data storage with one combinational read port and one synchronous write port.
- The FSM and handshake logic stay in icache.

Test Plan (INDEX_BITS=4):
- Cold miss: accept pc=0x0000_0040 → mem_fetch_enable=1, mem_addr=0x40 next cycle; mem_valid with mem_data=0x00A00093 → inst_valid=1, inst=0x00A00093 one cycle later, enable 0.
- Hit after fill: accept 0x40 again → inst_valid=1, inst=0x00A00093 next cycle, mem_fetch_enable stays 0; back-to-back hits on 0x40,0x44 (both filled) → two consecutive valid pulses.
- Conflict eviction: fill 0x40 (index 0, tag 1), then accept 0x00 (index 0, tag 0) → miss, fetch 0x00; then 0x40 → misses again.
- Clear mid-miss: miss on 0x80; clear two cycles later, mem_valid 3 cycles later with 0x12345678 → no inst_valid; req_ready 0 until after mem_valid; subsequent 0x80 request hits with 0x12345678.
- Clear coincident with mem_valid → line filled, inst_valid 0, state IDLE next cycle.
- rdy=0 for 5 cycles during MISS with mem_valid held low → outputs frozen, no fill; resumes normally. rst=0 during MISS → all valid bits cleared, enable 0, next access to same pc misses.
